// File: rtl/main_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : main_fsm_if
// Purpose  : Decoder-side instruction fields and datapath control strobes
//            exchanged with the multicycle ARM control state machine.
// Revision : 1.0 - initial release
// ============================================================================
interface main_fsm_if #(
    parameter int STATE_W = 4
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic               IRWrite;
    logic               AdrSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               NextPC;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic               ALUOp;
    logic [STATE_W-1:0] State;

    modport master (
        output Op, Funct,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        input  NextPC, RegW, MemW, Branch, ALUOp, State
    );

    modport slave (
        input  Op, Funct,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
        output NextPC, RegW, MemW, Branch, ALUOp, State
    );
endinterface
`default_nettype wire

// File: rtl/main_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_fsm
// Purpose  : Multicycle ARM main control FSM (Moore); steers the shared
//            datapath and issues pre-condition write requests.
// Revision : 1.0 - initial release
// ============================================================================
module main_fsm #(
    parameter int STATE_W = 4
) (
    input  wire           clk,
    input  wire           reset,
    main_fsm_if.slave     bus
);
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_MEMADR   = STATE_W'(2),
        S_MEMRD    = STATE_W'(3),
        S_MEMWB    = STATE_W'(4),
        S_MEMWR    = STATE_W'(5),
        S_EXECUTER = STATE_W'(6),
        S_EXECUTEI = STATE_W'(7),
        S_ALUWB    = STATE_W'(8),
        S_BRANCH   = STATE_W'(9)
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_unused;

    // Only I (Funct[5]) and L (Funct[0]) steer the sequence.
    assign w_unused = ^bus.Funct[4:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   w_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   w_next = S_MEMADR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.ALUOp     = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.NextPC    = 1'b1;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            S_MEMADR:   bus.ALUSrcB = 2'b01;
            S_MEMRD:    bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegW      = 1'b1;
            end
            S_MEMWR: begin
                bus.AdrSrc    = 1'b1;
                bus.MemW      = 1'b1;
            end
            S_EXECUTER: bus.ALUOp = 1'b1;
            S_EXECUTEI: begin
                bus.ALUSrcB   = 2'b01;
                bus.ALUOp     = 1'b1;
            end
            S_ALUWB:    bus.RegW = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.Branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.State = r_state;
endmodule
`default_nettype wire

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle ARM control state machine.
- Sits in the controller between the instruction decoder and the conditional-write logic.
- Its NextPC, RegW and MemW outputs feed the conditional-write logic, which gates them by the condition check.
- Its Branch output is combined with the decoded PC-write-from-result signal to form PCS; its datapath select and ALUOp outputs steer the shared multicycle datapath.

Parameters:
STATE_W, 4, width of state register and of debug State output (must be >= 4)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Op  input  2  instruction bits [27:26]: 00 data-processing, 01 memory, 10 branch, 11 illegal
Funct  input  6  instruction bits [25:20]: Funct[5] = I (immediate), Funct[0] = L (load)
IRWrite  output  1  instruction register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
ALUSrcA  output  2  ALU A select: 00 = register A, 01 = PC
ALUSrcB  output  2  ALU B select: 00 = register B, 01 = extended immediate, 10 = constant 4
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data register, 10 = ALU result (direct)
NextPC  output  1  unconditional PC write request (to conditional-write logic)
RegW  output  1  register write request, pre-condition
MemW  output  1  memory write request, pre-condition
Branch  output  1  branch-class instruction in branch state
ALUOp  output  1  1 = ALU decoder uses Funct; 0 = forced ADD
State  output  STATE_W  current state encoding, for debug/verification

Behaviour:
- Moore machine. All outputs are pure combinational decode of the state register, with no input-to-output paths.
- One state register, updated on the rising clk edge.
- reset asserted, any time, including mid-instruction: state forced to FETCH immediately, without waiting for a clock edge.
- While reset is held and in the first cycle after release, outputs are the FETCH values.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Codes 10..max are unused.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH (illegal, instruction dropped).
  - MEMADR: Funct[0]=1 -> MEMRD; Funct[0]=0 -> MEMWR.
  - MEMRD -> MEMWB; MEMWB -> FETCH; MEMWR -> FETCH.
  - EXECUTER -> ALUWB; EXECUTEI -> ALUWB; ALUWB -> FETCH; BRANCH -> FETCH.
  - Any unused code -> FETCH on the next edge.
- Output values per state. Unlisted strobes are 0, unlisted selects are 00, AdrSrc defaults to 0.
  - FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10, NextPC=1.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, ResultSrc=00, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1.
  - Unused codes: all outputs 0.
- Instruction latency, counted FETCH through last state inclusive: LDR 5 cycles; STR 4; data-processing 4; B 3; illegal 2.
- Op/Funct are sampled only in DECODE and MEMADR. Changes in other states must have no effect.
- At most one of RegW, MemW, NextPC, Branch is 1 in any cycle.

Test Plan:
- Reset then Op=01, Funct=000001 (LDR) held: State = 0,1,2,3,4,0. RegW=1 only in state 4, with ResultSrc=01. IRWrite=1 and NextPC=1 only in state 0.
- Op=01, Funct=000000 (STR): State = 0,1,2,5,0. MemW=1 and AdrSrc=1 in state 5 only. RegW stays 0 throughout.
- Op=00, Funct=001000 (ADD reg) then Funct=101000 (ADD imm):
  - reg form: states 0,1,6,8,0;
  - imm form: states 0,1,7,8,0;
  - ALUOp=1 only in 6/7; ALUSrcB=00 in 6 and 01 in 7.
- Op=10 (B): states 0,1,9,0. Branch=1, ALUSrcB=01, ResultSrc=10 in state 9. Op=11: states 0,1,0 with no write strobes.
- Assert reset asynchronously in MEMRD, away from any clk edge: State=0, IRWrite=1 and NextPC=1 immediately. After release, the next edge goes to DECODE.
- Toggle Op/Funct randomly in states other than DECODE/MEMADR: state sequence unchanged. Check no cycle has more than one of RegW/MemW/NextPC/Branch set.
